// File: rtl/kuramoto_pkg.sv
// Shared definitions for the Kuramoto synchrony episode controller.
//   sync_state_t : 2-bit synchrony FSM state codes (DESYNC=0, ONSET=1, SYNC=2, OFFSET=3)
//   FRAC         : fractional bits of R and thresholds (Q14, 1.0 = 16384)
//   R_*          : common Q14 threshold constants
package kuramoto_pkg;

  typedef enum logic [1:0] {
    StDesync = 2'd0,
    StOnset  = 2'd1,
    StSync   = 2'd2,
    StOffset = 2'd3
  } sync_state_t;

  localparam int unsigned FRAC  = 14;
  localparam int          R_ONE = 16384;
  localparam int          R_0P7 = 11469;
  localparam int          R_0P5 = 8192;
  localparam int          R_0P1 = 1638;

endpackage

// File: rtl/kuramoto_sync_episode_ctrl_if.sv
// Bus between the episode controller and its surroundings (tick/config in, order-block strobe
// and R in, sample and episode reports out).
//   slave  : controller side (drives kp_clk_en, sample/episode outputs)
//   master : upstream/order-block side (drives tick, config and kp_R)
interface kuramoto_sync_episode_ctrl_if #(
  parameter int unsigned WIDTH   = 18,
  parameter int unsigned DECIM_W = 16,
  parameter int unsigned HOLD_W  = 8,
  parameter int unsigned DUR_W   = 24
) ();
  import kuramoto_pkg::*;

  logic                      clk_en;
  logic                      enable;
  logic        [DECIM_W-1:0] decim;
  logic signed [WIDTH-1:0]   thr_on;
  logic signed [WIDTH-1:0]   thr_off;
  logic        [HOLD_W-1:0]  hold_n;
  logic                      kp_clk_en;
  logic signed [WIDTH-1:0]   kp_R;
  logic                      sample_valid;
  logic signed [WIDTH-1:0]   R_latched;
  sync_state_t               sync_state;
  logic                      in_sync;
  logic                      episode_done;
  logic        [DUR_W-1:0]   episode_len;
  logic        [15:0]        episode_count;

  modport slave (
    input  clk_en, enable, decim, thr_on, thr_off, hold_n, kp_R,
    output kp_clk_en, sample_valid, R_latched, sync_state, in_sync,
           episode_done, episode_len, episode_count
  );

  modport master (
    output clk_en, enable, decim, thr_on, thr_off, hold_n, kp_R,
    input  kp_clk_en, sample_valid, R_latched, sync_state, in_sync,
           episode_done, episode_len, episode_count
  );

endinterface

// File: rtl/kuramoto_decim_strobe.sv
// Decimates the system tick into the order-block strobe and flags the capture cycle.
//   clk, rst     : clock, synchronous active-high reset
//   clk_en       : system tick
//   enable       : run; low clears the decimation counter and blocks the strobe
//   decim        : ticks per measurement (0 behaves as 1)
//   kp_clk_en    : strobe to the order block
//   sample_valid : strobe delayed one cycle (order block output is valid then)
module kuramoto_decim_strobe #(
  parameter int unsigned DECIM_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  input  logic               enable,
  input  logic [DECIM_W-1:0] decim,
  output logic               kp_clk_en,
  output logic               sample_valid
);

  logic [DECIM_W-1:0] cnt_q;
  logic [DECIM_W-1:0] limit;
  logic               hit;

  // >= rather than == so a decim shrunk below the running count wraps at the next tick.
  assign limit     = (decim == '0) ? '0 : decim - DECIM_W'(1);
  assign hit       = (cnt_q >= limit);
  assign kp_clk_en = clk_en & enable & hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= kp_clk_en;
      if (!enable) begin
        cnt_q <= '0;
      end else if (clk_en) begin
        cnt_q <= hit ? '0 : cnt_q + DECIM_W'(1);
      end
    end
  end

endmodule

// File: rtl/kuramoto_sync_episode_ctrl.sv
// Sequencer/monitor for kuramoto_order_parameter: strobes the order block at a decimated tick,
// captures R, runs a hysteretic debounced synchrony FSM and reports synchrony episodes.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of kuramoto_sync_episode_ctrl_if (config, kp strobe/R, reports)
module kuramoto_sync_episode_ctrl
  import kuramoto_pkg::*;
#(
  parameter int unsigned WIDTH   = 18,
  parameter int unsigned DECIM_W = 16,
  parameter int unsigned HOLD_W  = 8,
  parameter int unsigned DUR_W   = 24
) (
  input logic clk,
  input logic rst,
  kuramoto_sync_episode_ctrl_if.slave bus
);

  logic kp_clk_en;
  logic sample_valid;

  kuramoto_decim_strobe #(
    .DECIM_W(DECIM_W)
  ) u_decim (
    .clk          (clk),
    .rst          (rst),
    .clk_en       (bus.clk_en),
    .enable       (bus.enable),
    .decim        (bus.decim),
    .kp_clk_en    (kp_clk_en),
    .sample_valid (sample_valid)
  );

  sync_state_t             state_q, state_d;
  logic [HOLD_W-1:0]       run_q, run_d;
  logic [DUR_W-1:0]        len_q, len_d;
  logic [DUR_W-1:0]        ep_len_q, ep_len_d;
  logic [15:0]             ep_cnt_q, ep_cnt_d;
  logic                    done_q, done_d;
  logic signed [WIDTH-1:0] r_latched_q;

  logic [HOLD_W-1:0] hold_eff;
  logic [HOLD_W:0]   run_inc;
  logic              run_hit;
  logic              ge_on;
  logic              lt_off;
  logic [DUR_W-1:0]  len_inc;

  assign hold_eff = (bus.hold_n == '0) ? HOLD_W'(1) : bus.hold_n;
  assign run_inc  = {1'b0, run_q} + (HOLD_W + 1)'(1);
  // >= keeps a hold_n lowered mid-run from stranding the counter past its target.
  assign run_hit  = (run_inc >= {1'b0, hold_eff});
  assign ge_on    = ($signed(bus.kp_R) >= $signed(bus.thr_on));
  assign lt_off   = ($signed(bus.kp_R) < $signed(bus.thr_off));
  assign len_inc  = (&len_q) ? len_q : len_q + DUR_W'(1);

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    len_d    = len_q;
    ep_len_d = ep_len_q;
    ep_cnt_d = ep_cnt_q;
    done_d   = 1'b0;
    if (!bus.enable) begin
      // Abort: drop any episode in progress without reporting it.
      state_d = StDesync;
      run_d   = '0;
      len_d   = '0;
    end else if (sample_valid) begin
      unique case (state_q)
        StDesync: begin
          if (ge_on) begin
            if (hold_eff == HOLD_W'(1)) begin
              state_d = StSync;
              run_d   = '0;
              len_d   = DUR_W'(1);
            end else begin
              state_d = StOnset;
              run_d   = HOLD_W'(1);
            end
          end
        end
        StOnset: begin
          if (!ge_on) begin
            state_d = StDesync;
            run_d   = '0;
          end else if (run_hit) begin
            state_d = StSync;
            run_d   = '0;
            len_d   = DUR_W'(1);
          end else begin
            run_d = run_inc[HOLD_W-1:0];
          end
        end
        StSync: begin
          len_d = len_inc;
          if (lt_off) begin
            state_d = StOffset;
            run_d   = HOLD_W'(1);
          end
        end
        StOffset: begin
          len_d = len_inc;
          if (!lt_off) begin
            state_d = StSync;
            run_d   = '0;
          end else begin
            run_d = run_inc[HOLD_W-1:0];
          end
        end
      endcase
      // Episode end: SYNC with single-sample hold, or OFFSET reaching the hold count.
      if (lt_off && ((state_q == StSync && hold_eff == HOLD_W'(1)) ||
                     (state_q == StOffset && run_hit))) begin
        state_d  = StDesync;
        run_d    = '0;
        len_d    = '0;
        ep_len_d = len_q;
        ep_cnt_d = (&ep_cnt_q) ? ep_cnt_q : ep_cnt_q + 16'd1;
        done_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StDesync;
      run_q       <= '0;
      len_q       <= '0;
      ep_len_q    <= '0;
      ep_cnt_q    <= '0;
      done_q      <= 1'b0;
      r_latched_q <= '0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      len_q    <= len_d;
      ep_len_q <= ep_len_d;
      ep_cnt_q <= ep_cnt_d;
      done_q   <= done_d;
      if (sample_valid) begin
        r_latched_q <= bus.kp_R;
      end
    end
  end

  assign bus.kp_clk_en     = kp_clk_en;
  assign bus.sample_valid  = sample_valid;
  assign bus.R_latched     = r_latched_q;
  assign bus.sync_state    = state_q;
  assign bus.in_sync       = (state_q == StSync) || (state_q == StOffset);
  assign bus.episode_done  = done_q;
  assign bus.episode_len   = ep_len_q;
  assign bus.episode_count = ep_cnt_q;

endmodule
